// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: state encodings and the
// default address/instruction width.
package fetch_redirect_ctrl_pkg;

    localparam int FRC_WORD = 16;

    typedef enum logic [1:0] {
        FRC_FETCH  = 2'd0,
        FRC_SQUASH = 2'd1,
        FRC_HOLD   = 2'd2
    } frc_state_e;

    localparam logic [15:0] FLUSH_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fetch_hold_buffer.sv
// Single-entry pc/instruction holding register used while the ID stage is stalled
// and a fetched instruction has already been acknowledged by memory.
module fetch_hold_buffer
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int WORD = FRC_WORD
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            clear,
    input  logic [WORD-1:0] load_pc,
    input  logic [WORD-1:0] load_instr,
    output logic            valid,
    output logic [WORD-1:0] pc,
    output logic [WORD-1:0] instr
);

    logic            valid_reg;
    logic [WORD-1:0] pc_reg;
    logic [WORD-1:0] instr_reg;

    // Clear wins over load so a squash in the same cycle leaves the entry empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end
    end

    assign valid = valid_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch stage: PC register, instruction-memory handshake and IF/ID register, with
// flush redirect and stall handling. Optional flush event counter: FLUSH_COUNT_EN.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int              WORD     = FRC_WORD,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_signal,
    input  logic [WORD-1:0] flush_target,
    input  logic            stall,
    output logic            i_req,
    output logic [WORD-1:0] i_addr,
    input  logic            i_ack,
    input  logic [WORD-1:0] i_data,
    output logic            ifid_valid,
    output logic [WORD-1:0] ifid_pc,
    output logic [WORD-1:0] ifid_instr,
    output logic [15:0]     flush_count
);

    frc_state_e      state_reg, state_next;
    logic [WORD-1:0] pc_reg, pc_next;
    logic [WORD-1:0] pending_reg, pending_next;
    logic            ifid_valid_reg, ifid_valid_next;
    logic [WORD-1:0] ifid_pc_reg, ifid_pc_next;
    logic [WORD-1:0] ifid_instr_reg, ifid_instr_next;

    logic            buf_load;
    logic            buf_clear;
    logic            buf_valid;
    logic [WORD-1:0] buf_pc;
    logic [WORD-1:0] buf_instr;

    logic            load_ifid;
    logic [WORD-1:0] load_pc;
    logic [WORD-1:0] load_instr;

    fetch_hold_buffer #(
        .WORD(WORD)
    ) u_hold_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (pc_reg),
        .load_instr (i_data),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    // In SQUASH the old address keeps being presented until memory acknowledges.
    assign i_req  = reset_n && (state_reg != FRC_HOLD);
    assign i_addr = pc_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pending_next    = pending_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        buf_load        = 1'b0;
        buf_clear       = 1'b0;
        load_ifid       = 1'b0;
        load_pc         = pc_reg;
        load_instr      = i_data;

        case (state_reg)
            FRC_FETCH: begin
                if (i_ack) begin
                    if (flush_signal) begin
                        pc_next = flush_target;
                    end else if (stall) begin
                        buf_load   = 1'b1;
                        state_next = FRC_HOLD;
                    end else begin
                        load_ifid = 1'b1;
                        pc_next   = pc_reg + WORD'(1);
                    end
                end else if (flush_signal) begin
                    pending_next = flush_target;
                    state_next   = FRC_SQUASH;
                end
            end
            FRC_SQUASH: begin
                if (i_ack) begin
                    pc_next    = flush_signal ? flush_target : pending_reg;
                    state_next = FRC_FETCH;
                end else if (flush_signal) begin
                    pending_next = flush_target;
                end
            end
            FRC_HOLD: begin
                if (flush_signal) begin
                    buf_clear  = 1'b1;
                    pc_next    = flush_target;
                    state_next = FRC_FETCH;
                end else if (!stall) begin
                    load_ifid  = buf_valid;
                    load_pc    = buf_pc;
                    load_instr = buf_instr;
                    pc_next    = buf_pc + WORD'(1);
                    buf_clear  = 1'b1;
                    state_next = FRC_FETCH;
                end
            end
            default: begin
                state_next = FRC_FETCH;
            end
        endcase

        // Flush beats stall; an idle unstalled cycle inserts a bubble.
        if (flush_signal) begin
            ifid_valid_next = 1'b0;
        end else if (load_ifid) begin
            ifid_valid_next = 1'b1;
            ifid_pc_next    = load_pc;
            ifid_instr_next = load_instr;
        end else if (!stall) begin
            ifid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= FRC_FETCH;
            pc_reg         <= RESET_PC;
            pending_reg    <= '0;
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pending_reg    <= pending_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
        end
    end

    assign ifid_valid = ifid_valid_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_instr = ifid_instr_reg;

`ifdef FLUSH_COUNT_EN
    logic [15:0] flush_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_count_reg <= '0;
        end else if (flush_signal && (flush_count_reg != FLUSH_COUNT_MAX)) begin
            flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    assign flush_count = flush_count_reg;
`else
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: vector table with an IF/ID
// scoreboard, plus reset-abandon and flush-counter sequences.
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        reset_n;
    logic        flush_signal;
    logic [15:0] flush_target;
    logic        stall;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_data;
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_instr;
    logic [15:0] flush_count;

    int errors = 0;
    int checks = 0;

    fetch_redirect_ctrl #(
        .WORD     (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_signal (flush_signal),
        .flush_target (flush_target),
        .stall        (stall),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_data       (i_data),
        .ifid_valid   (ifid_valid),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [15:0] target;
        logic        stall;
        logic        ack;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_pc;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    localparam logic [15:0] DATA_KEY = 16'h5A00;

    function automatic vec_t mkv(logic fl, logic [15:0] tg, logic st, logic ak,
                                 logic rq, logic [15:0] ad, logic vl, logic [15:0] pc);
        vec_t v;
        v.flush = fl; v.target = tg; v.stall = st; v.ack = ak;
        v.exp_req = rq; v.exp_addr = ad; v.exp_valid = vl; v.exp_pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        flush_signal = v.flush;
        flush_target = v.target;
        stall        = v.stall;
        i_ack        = v.ack;
        i_data       = v.ack ? (v.exp_addr ^ DATA_KEY) : 16'hDEAD;
        #1;
        check($sformatf("v%0d i_req", idx), {15'd0, i_req}, {15'd0, v.exp_req});
        if (v.exp_req) check($sformatf("v%0d i_addr", idx), i_addr, v.exp_addr);
        e.valid = v.exp_valid;
        e.pc    = v.exp_pc;
        e.instr = v.exp_pc ^ DATA_KEY;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: got empty queue expected one entry", idx);
        end else begin
            got = sb.pop_front();
            check($sformatf("v%0d ifid_valid", idx), {15'd0, ifid_valid}, {15'd0, got.valid});
            if (got.valid) begin
                check($sformatf("v%0d ifid_pc", idx), ifid_pc, got.pc);
                check($sformatf("v%0d ifid_instr", idx), ifid_instr, got.instr);
            end
        end
        $display("vec %0d: req=%0b addr=%04h ifid_valid=%0b ifid_pc=%04h ifid_instr=%04h",
                 idx, v.exp_req, i_addr, ifid_valid, ifid_pc, ifid_instr);
    endtask

    initial begin
        // Fields: flush, target, stall, ack | exp_req, exp_addr, exp_valid, exp_pc
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0000, 1, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0001, 1, 16'h0001));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0002, 1, 16'h0002));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0003, 1, 16'h0003));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0004, 1, 16'h0004));
        vecs.push_back(mkv(1, 16'h0040, 0, 1, 1, 16'h0005, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0040, 1, 16'h0040));
        vecs.push_back(mkv(1, 16'h0010, 0, 1, 1, 16'h0041, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 0, 1, 16'h0010, 0, 16'h0000));
        vecs.push_back(mkv(1, 16'h0080, 0, 0, 1, 16'h0010, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 0, 1, 16'h0010, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0010, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0080, 1, 16'h0080));
        vecs.push_back(mkv(1, 16'h001F, 0, 1, 1, 16'h0081, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h001F, 1, 16'h001F));
        vecs.push_back(mkv(0, 16'h0000, 1, 1, 1, 16'h0020, 1, 16'h001F));
        vecs.push_back(mkv(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 16'h001F));
        vecs.push_back(mkv(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 16'h001F));
        vecs.push_back(mkv(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0020));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0021, 1, 16'h0021));
        vecs.push_back(mkv(0, 16'h0000, 1, 1, 1, 16'h0022, 1, 16'h0021));
        vecs.push_back(mkv(1, 16'h0033, 1, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0033, 1, 16'h0033));
        vecs.push_back(mkv(1, 16'hFFFF, 0, 1, 1, 16'h0034, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'hFFFF, 1, 16'hFFFF));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0000, 1, 16'h0000));
        vecs.push_back(mkv(1, 16'h0100, 0, 0, 1, 16'h0001, 0, 16'h0000));
        vecs.push_back(mkv(1, 16'h0200, 0, 0, 1, 16'h0001, 0, 16'h0000));
        vecs.push_back(mkv(1, 16'h0300, 0, 1, 1, 16'h0001, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0300, 1, 16'h0300));
        vecs.push_back(mkv(1, 16'h0400, 0, 0, 1, 16'h0301, 0, 16'h0000));
        vecs.push_back(mkv(1, 16'h0500, 0, 0, 1, 16'h0301, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0301, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0500, 1, 16'h0500));
        vecs.push_back(mkv(0, 16'h0000, 0, 0, 1, 16'h0501, 0, 16'h0000));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0501, 1, 16'h0501));
        vecs.push_back(mkv(0, 16'h0000, 1, 0, 1, 16'h0502, 1, 16'h0501));
        vecs.push_back(mkv(0, 16'h0000, 0, 1, 1, 16'h0502, 1, 16'h0502));

        reset_n      = 1'b0;
        flush_signal = 1'b0;
        flush_target = 16'h0000;
        stall        = 1'b0;
        i_ack        = 1'b0;
        i_data       = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check("reset i_req", {15'd0, i_req}, 16'd0);
        check("reset ifid_valid", {15'd0, ifid_valid}, 16'd0);
        check("reset ifid_pc", ifid_pc, 16'h0000);
        check("reset ifid_instr", ifid_instr, 16'h0000);
        check("reset flush_count", flush_count, 16'h0000);
        $display("reset: i_req=%0b ifid_valid=%0b flush_count=%0d", i_req, ifid_valid, flush_count);

        @(negedge clk);
        reset_n = 1'b1;
        foreach (vecs[i]) apply(i, vecs[i]);

`ifdef FLUSH_COUNT_EN
        check("table flush_count", flush_count, 16'd11);
`else
        check("table flush_count", flush_count, 16'd0);
`endif
        $display("table end: flush_count=%0d", flush_count);

        // Reset asserted while a fetch is outstanding abandons it immediately.
        @(negedge clk);
        flush_signal = 1'b0;
        stall        = 1'b0;
        i_ack        = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midfetch reset i_req", {15'd0, i_req}, 16'd0);
        check("midfetch reset ifid_valid", {15'd0, ifid_valid}, 16'd0);
        check("midfetch reset ifid_pc", ifid_pc, 16'h0000);
        check("midfetch reset flush_count", flush_count, 16'h0000);
        $display("midfetch reset: i_req=%0b ifid_valid=%0b", i_req, ifid_valid);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post reset i_addr", i_addr, 16'h0000);
        check("post reset i_req", {15'd0, i_req}, 16'd1);

        // Five consecutive flush cycles, each redirecting an acknowledged fetch.
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            flush_signal = 1'b1;
            flush_target = 16'h0700 + 16'(k);
            i_ack        = 1'b1;
            i_data       = 16'hBEEF;
            #1;
            check($sformatf("flush%0d i_addr", k), i_addr, (k == 0) ? 16'h0000 : 16'h0700 + 16'(k - 1));
            @(posedge clk);
            #1;
            check($sformatf("flush%0d ifid_valid", k), {15'd0, ifid_valid}, 16'd0);
            $display("flush %0d: i_addr=%04h flush_count=%0d", k, i_addr, flush_count);
        end
`ifdef FLUSH_COUNT_EN
        check("flush_count after 5", flush_count, 16'd5);
`else
        check("flush_count after 5", flush_count, 16'd0);
`endif
        @(negedge clk);
        flush_signal = 1'b0;
        i_ack        = 1'b1;
        i_data       = 16'h0704 ^ DATA_KEY;
        #1;
        check("redirect i_addr", i_addr, 16'h0704);
        @(posedge clk);
        #1;
        check("redirect ifid_valid", {15'd0, ifid_valid}, 16'd1);
        check("redirect ifid_pc", ifid_pc, 16'h0704);
        check("redirect ifid_instr", ifid_instr, 16'h0704 ^ DATA_KEY);
        $display("redirect: ifid_pc=%04h ifid_instr=%04h", ifid_pc, ifid_instr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Consumer side of the pipeline flush path. It owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It applies `flush_signal` and `flush_target` from the flush unit and `stall` from the hazard unit. It sits between instruction memory and the ID stage, and guarantees that no squashed or wrong-path instruction ever reaches IF/ID with `ifid_valid=1`.

## Interface
- `WORD`, default 16: address and instruction width (word-addressed ISA).
- `RESET_PC`, default 0: PC value loaded at reset.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush_signal`  in  1  squash younger instructions and redirect fetch.
- `flush_target`  in  WORD  redirect PC; valid when `flush_signal=1`.
- `stall`  in  1  hold IF/ID and PC (load-use hazard).
- `i_req`  out  1  instruction fetch request.
- `i_addr`  out  WORD  fetch address; stable while `i_req=1` until ack.
- `i_ack`  in  1  fetch complete; `i_data` valid this cycle. May arrive in the same cycle as `i_req` or later.
- `i_data`  in  WORD  fetched instruction.
- `ifid_valid`  out  1  IF/ID holds a live instruction.
- `ifid_pc`  out  WORD  PC of the IF/ID instruction.
- `ifid_instr`  out  WORD  IF/ID instruction.
- `flush_count`  out  16  flush event counter (see Configuration).

## Operation
- States: FETCH, SQUASH, HOLD.
- **FETCH**
  - `i_req=1`, `i_addr=pc`.
  - On `i_ack`:
    - with `flush_signal`: discard data; `pc<=flush_target`; stay in FETCH.
    - else with `stall`: capture `i_data` and `pc` into the hold buffer; go to HOLD.
    - else: load IF/ID (`valid=1`, `pc`, `i_data`); `pc<=pc+1`.
  - No `i_ack` but `flush_signal`: save `flush_target` as the pending target; go to SQUASH. `i_addr` is unchanged.
- **SQUASH**
  - `i_req=1` with the old `i_addr` until ack.
  - A new `flush_signal` overwrites the pending target.
  - On `i_ack`: discard data. `pc<=pending` target, or `flush_target` if `flush_signal` is high in the ack cycle. Go to FETCH.
- **HOLD**
  - `i_req=0`.
  - `flush_signal`: discard the buffer; `pc<=flush_target`; go to FETCH.
  - Else, when `stall=0`: move the buffer into IF/ID; `pc<=buffered pc+1`; go to FETCH.
- IF/ID update rules, in priority order:
  - `flush_signal` forces `ifid_valid<=0` in every state. Flush has priority over stall.
  - Else `stall` holds IF/ID unchanged.
  - Else, if no instruction is loaded this cycle, `ifid_valid<=0` (bubble).
- PC arithmetic: `pc+1` modulo 2^WORD. 0xFFFF wraps to 0x0000.
- Reset values:
  - `pc=RESET_PC`, state FETCH.
  - `i_req=0` while `reset_n=0`.
  - `ifid_valid=0`, `ifid_pc=0`, `ifid_instr=0`, `flush_count=0`.
  - Hold buffer and pending target are cleared.
- Reset asserted mid-fetch: the outstanding request is abandoned. Memory tolerates `i_req` dropping without ack.

## Timing
- First `i_req` appears in the first cycle with `reset_n=1`.
- Fetch latency: IF/ID updates on the clock edge that ends the `i_ack` cycle. With same-cycle ack, throughput is 1 instruction per cycle.
- Flush to redirected request:
  - From FETCH with ack, or from HOLD: the cycle after `flush_signal`.
  - From SQUASH: the cycle after the in-flight ack.
- Stall release from HOLD: IF/ID loads on the edge ending the first `stall=0` cycle. The next `i_req` is issued in the following cycle.
- Outputs are registered. The only combinational outputs are `i_req` and `i_addr`, which are decoded from state and PC.

## Configuration
- `FLUSH_COUNT_EN` defined: `flush_count` increments by 1 on every cycle with `flush_signal=1`, saturating at 0xFFFF. It is cleared only by reset.
- `FLUSH_COUNT_EN` undefined: `flush_count` is tied to 0 and no counter register is built.

## Structure
- Shared include (alongside `opcodes.v`) holds:
  - state encodings `FRC_FETCH`/`FRC_SQUASH`/`FRC_HOLD` (2 bits);
  - the `WORD` default.
- One sub-module: `fetch_hold_buffer`. It is a single-entry pc/instr register with `load`, `clear` and `valid`, used by HOLD.

## Test plan
- Reset release, `RESET_PC=0`, ack in the same cycle as req, no stall → `i_addr` 0,1,2,3 on consecutive cycles; IF/ID pc 0,1,2 with `ifid_valid=1` from cycle 2.
- `flush_signal=1`, `flush_target=0x0040` in the ack cycle of the fetch at 0x0005 → the 0x0005 instruction is never valid in IF/ID; `ifid_valid=0` for one cycle; next `i_addr=0x0040`.
- Flush (target 0x0080) while the fetch at 0x0010 awaits ack (3-cycle latency) → `i_addr` stays at 0x0010 until ack; that data is discarded; next `i_addr=0x0080`.
- Stall for 3 cycles coincident with ack at 0x0020 → `i_req=0`; IF/ID frozen; after release, IF/ID pc=0x0020 and the next `i_addr=0x0021`.
- `stall=1` and `flush_signal=1` in the same cycle while in HOLD → `ifid_valid=0`; buffer discarded; next `i_addr=flush_target`.
- PC at 0xFFFF, no stall → next `i_addr=0x0000`. With `FLUSH_COUNT_EN`, 5 flush cycles give `flush_count=5`; without it, `flush_count=0`.
